// File: rtl/csa_serial_adder_pkg.sv
// Shared types for the two-bit-per-cycle serial adder: FSM encoding and digit helpers.
package csa_serial_adder_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int digits(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/csa_serial_adder_if.sv
// Operand/result handshake bundle between a producer/consumer and the serial adder.
interface csa_serial_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/CSA2.sv
// Two-bit carry-select adder slice: both carry cases are precomputed, cin_2 picks one.
module CSA2 (
    input  logic [1:0] op1_2,
    input  logic [1:0] op2_2,
    input  logic       cin_2,
    output logic [1:0] sum_2,
    output logic       cout_2
);
    logic [2:0] r0;
    logic [2:0] r1;

    assign r0 = {1'b0, op1_2} + {1'b0, op2_2};
    assign r1 = r0 + 3'd1;
    assign {cout_2, sum_2} = cin_2 ? r1 : r0;
endmodule

// File: rtl/csa_serial_adder.sv
// Multi-cycle WIDTH-bit adder: feeds one CSA2 slice two bits per clock, LSB digit first.
module csa_serial_adder
    import csa_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    csa_serial_adder_if.slave  bus
);
    localparam int DIGITS = digits(WIDTH);
    localparam int NW     = $clog2(DIGITS) + 1;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
            $error("csa_serial_adder: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic [NW-1:0]    n;

    logic [1:0]       sum_2;
    logic             cout_2;
    logic [WIDTH+1:0] s_ext;

    CSA2 u_csa2 (
        .op1_2  (a[1:0]),
        .op2_2  (b[1:0]),
        .cin_2  (c),
        .sum_2  (sum_2),
        .cout_2 (cout_2)
    );

    // New digit enters at the top; the extended view keeps WIDTH=2 legal.
    assign s_ext = {sum_2, s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a     <= '0;
            b     <= '0;
            s     <= '0;
            c     <= 1'b0;
            n     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a     <= bus.op_a;
                        b     <= bus.op_b;
                        c     <= bus.cin;
                        n     <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a <= a >> 2;
                    b <= b >> 2;
                    s <= s_ext[WIDTH+1:2];
                    c <= cout_2;
                    n <= n + 1'b1;
                    if (n == NW'(DIGITS - 1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs depend on state only; rst masks in_ready during the reset cycle.
    assign bus.in_ready  = (state == ST_IDLE) && !rst;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.sum       = s;
    assign bus.cout      = c;
endmodule
